// File: rtl/sprite_compositor_pkg.sv
// sprite_compositor_pkg: shared video constants, sprite geometry defaults and packed-bus helpers.
package sprite_compositor_pkg;
   localparam int RES_H      = 640;
   localparam int RES_V      = 480;
   localparam int PIXEL_FREQ = 25_175_000;
   localparam int SPR_W      = 16;
   localparam int SPR_H      = 8;
   localparam int SCALE_LOG2 = 1;
   localparam int POS_W      = 10;
   localparam int COLOR_W    = 8;
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction
endpackage

// File: rtl/sprite_hit.sv
// sprite_hit: per-channel box test and bitmap lookup for the current pixel.
module sprite_hit
   import sprite_compositor_pkg::*;
#(
   parameter int SPR_W      = sprite_compositor_pkg::SPR_W,
   parameter int SPR_H      = sprite_compositor_pkg::SPR_H,
   parameter int SCALE_LOG2 = sprite_compositor_pkg::SCALE_LOG2,
   parameter int POS_W      = sprite_compositor_pkg::POS_W
) (
   input  logic [POS_W-1:0]       pixel_x,
   input  logic [POS_W-1:0]       pixel_y,
   input  logic [POS_W-1:0]       x,
   input  logic [POS_W-1:0]       y,
   input  logic                   en,
   input  logic [SPR_W*SPR_H-1:0] bitmap,
   output logic                   hit,
   output logic                   opaque
);
   localparam int IW = $clog2(SPR_W * SPR_H);
   localparam logic [POS_W:0] W_MAX = (POS_W+1)'(SPR_W << SCALE_LOG2);
   localparam logic [POS_W:0] H_MAX = (POS_W+1)'(SPR_H << SCALE_LOG2);
   logic [POS_W:0] dx, dy, sx, sy;
   logic [IW-1:0]  idx;
   // one extra bit so a pixel left of / above the sprite shows up as negative
   assign dx  = {1'b0, pixel_x} - {1'b0, x};
   assign dy  = {1'b0, pixel_y} - {1'b0, y};
   assign sx  = dx >> SCALE_LOG2;
   assign sy  = dy >> SCALE_LOG2;
   assign idx = IW'(sy * (POS_W+1)'(SPR_W) + sx);
   assign hit    = en && !dx[POS_W] && !dy[POS_W] && dx < W_MAX && dy < H_MAX;
   assign opaque = hit && bitmap[idx];
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: draws NUM_SPRITES scaled bitmap sprites over a background with
// fixed priority, per-frame collision flags and 2-strobe aligned sync outputs.
module sprite_compositor
   import sprite_compositor_pkg::*;
#(
   parameter int NUM_SPRITES = 4,
   parameter int RES_H       = sprite_compositor_pkg::RES_H,
   parameter int RES_V       = sprite_compositor_pkg::RES_V,
   parameter int SPR_W       = sprite_compositor_pkg::SPR_W,
   parameter int SPR_H       = sprite_compositor_pkg::SPR_H,
   parameter int SCALE_LOG2  = sprite_compositor_pkg::SCALE_LOG2,
   parameter int POS_W       = sprite_compositor_pkg::POS_W
) (
   input  logic                                 clk,
   input  logic                                 arst_n,
   input  logic                                 pix_en,
   input  logic                                 hsync_in,
   input  logic                                 vsync_in,
   input  logic                                 data_enable,
   input  logic                                 frame,
   input  logic [NUM_SPRITES*POS_W-1:0]         spr_x,
   input  logic [NUM_SPRITES*POS_W-1:0]         spr_y,
   input  logic [NUM_SPRITES-1:0]               spr_en,
   input  logic [NUM_SPRITES*COLOR_W-1:0]       spr_color,
   input  logic [NUM_SPRITES*SPR_W*SPR_H-1:0]   spr_bitmap,
   input  logic [COLOR_W-1:0]                   bg_color,
   output logic [COLOR_W-1:0]                   vga_out,
   output logic                                 hsync,
   output logic                                 vsync,
   output logic [NUM_SPRITES-1:0]               collision,
   output logic                                 collision_valid
);
   localparam int N  = NUM_SPRITES;
   localparam int BM = SPR_W * SPR_H;
   localparam logic [POS_W-1:0] X_LAST = POS_W'(RES_H - 1);
   localparam logic [POS_W-1:0] Y_LAST = POS_W'(RES_V - 1);
   logic [POS_W-1:0]   pixel_x, pixel_y, px, py;
   logic [N*POS_W-1:0] sh_x, sh_y, ex, ey;
   logic [N*COLOR_W-1:0] sh_color, ec;
   logic [N-1:0]       sh_en, ee, hit, opaque, opq, acc;
   logic [COLOR_W-1:0] win_color, col1;
   logic               win, any1, de1, hs1, vs1, live1, started, multi;
   // the frame strobe is pixel (0,0) of the new frame and already uses the newly latched sprite state
   assign px = frame ? '0 : pixel_x;
   assign py = frame ? '0 : pixel_y;
   assign ex = frame ? spr_x : sh_x;
   assign ey = frame ? spr_y : sh_y;
   assign ee = frame ? spr_en : sh_en;
   assign ec = frame ? spr_color : sh_color;
   assign opq   = hit & opaque;
   assign multi = data_enable && |(opq & (opq - N'(1)));
   for (genvar g = 0; g < N; g++) begin : g_hit
      sprite_hit #(
         .SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE_LOG2(SCALE_LOG2), .POS_W(POS_W)
      ) u_hit (
         .pixel_x(px),
         .pixel_y(py),
         .x(ex[slice_lo(g, POS_W) +: POS_W]),
         .y(ey[slice_lo(g, POS_W) +: POS_W]),
         .en(ee[g]),
         .bitmap(spr_bitmap[slice_lo(g, BM) +: BM]),
         .hit(hit[g]),
         .opaque(opaque[g])
      );
   end
   always_comb begin
      win = 1'b0;
      win_color = '0;
      for (int i = N - 1; i >= 0; i--)
         if (opq[i]) begin
            win = 1'b1;
            win_color = ec[slice_lo(i, COLOR_W) +: COLOR_W];
         end
   end
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         pixel_x <= '0;
         pixel_y <= '0;
      end else if (pix_en) begin
         if (frame) begin
            pixel_x <= data_enable ? POS_W'(1) : '0;
            pixel_y <= '0;
         end else if (data_enable) begin
            pixel_x <= (pixel_x == X_LAST) ? '0 : pixel_x + 1'b1;
            if (pixel_x == X_LAST) pixel_y <= (pixel_y == Y_LAST) ? '0 : pixel_y + 1'b1;
         end
      end
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         sh_x <= '0;
         sh_y <= '0;
         sh_en <= '0;
         sh_color <= '0;
         started <= 1'b0;
      end else if (pix_en && frame) begin
         sh_x <= spr_x;
         sh_y <= spr_y;
         sh_en <= spr_en;
         sh_color <= spr_color;
         started <= 1'b1;
      end
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         any1 <= 1'b0;
         col1 <= '0;
         de1 <= 1'b0;
         hs1 <= 1'b0;
         vs1 <= 1'b0;
         live1 <= 1'b0;
         vga_out <= '0;
         hsync <= 1'b0;
         vsync <= 1'b0;
         acc <= '0;
         collision <= '0;
         collision_valid <= 1'b0;
      end else begin
         collision_valid <= pix_en && frame;
         if (pix_en) begin
            any1 <= win;
            col1 <= win_color;
            de1 <= data_enable;
            hs1 <= hsync_in;
            vs1 <= vsync_in;
            live1 <= started || frame;
            vga_out <= (de1 && live1) ? (any1 ? col1 : bg_color) : '0;
            hsync <= hs1;
            vsync <= vs1;
            acc <= (frame ? '0 : acc) | (multi ? opq : '0);
            if (frame) collision <= acc;
         end
      end
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed line-by-line stimulus with hand-computed pixel expectations.
module tb_sprite_compositor;
   localparam int N  = 4;
   localparam int PW = 10;
   localparam int BM = 128;
   localparam int HT = 644;
   logic clk = 1'b0, arst_n = 1'b0, pix_en = 1'b1;
   logic hsync_in = 1'b0, vsync_in = 1'b0, data_enable = 1'b0, frame = 1'b0;
   logic [N*PW-1:0] spr_x = '0, spr_y = '0;
   logic [N-1:0]    spr_en = '0;
   logic [N*8-1:0]  spr_color = '0;
   logic [N*BM-1:0] spr_bitmap = '0;
   logic [7:0]      bg_color = 8'h25;
   logic [7:0]      vga0, vga1;
   logic            hs0, vs0, hs1, vs1, cv0, cv1;
   logic [N-1:0]    col0, col1;
   logic [7:0]      lb [HT];
   logic [7:0]      lb1 [HT];
   logic            hb [HT];
   logic [N-1:0]    col_f;
   logic            cv_f, cv_n;
   int              checks = 0, errors = 0, stall_k = -1;
   always #5 clk = ~clk;
   sprite_compositor #(.NUM_SPRITES(N), .SCALE_LOG2(1)) u0 (
      .clk(clk), .arst_n(arst_n), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .data_enable(data_enable), .frame(frame), .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en),
      .spr_color(spr_color), .spr_bitmap(spr_bitmap), .bg_color(bg_color), .vga_out(vga0),
      .hsync(hs0), .vsync(vs0), .collision(col0), .collision_valid(cv0)
   );
   sprite_compositor #(.NUM_SPRITES(N), .SCALE_LOG2(0)) u1 (
      .clk(clk), .arst_n(arst_n), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .data_enable(data_enable), .frame(frame), .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en),
      .spr_color(spr_color), .spr_bitmap(spr_bitmap), .bg_color(bg_color), .vga_out(vga1),
      .hsync(hs1), .vsync(vs1), .collision(col1), .collision_valid(cv1)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // after strobe k the outputs show pixel k-1
   task automatic do_line(input logic fr);
      for (int k = 0; k < HT; k++) begin
         data_enable = k < 640;
         frame = fr && k == 0;
         hsync_in = k >= 641;
         step();
         if (k >= 1) begin
            lb[k-1] = vga0;
            lb1[k-1] = vga1;
            hb[k-1] = hs0;
         end
         if (fr && k == 0) begin
            col_f = col0;
            cv_f = cv0;
         end
         if (fr && k == 1) cv_n = cv0;
         if (k == stall_k) begin
            pix_en = 1'b0;
            repeat (3) step();
            chk("stall_hold", vga0, 8'h1C);
            pix_en = 1'b1;
         end
      end
      data_enable = 1'b0;
      frame = 1'b0;
      hsync_in = 1'b0;
   endtask
   initial begin
      repeat (3) step();
      chk("rst_vga", vga0, 8'h00);
      chk("rst_hsync", hs0, 1'b0);
      chk("rst_vsync", vs0, 1'b0);
      chk("rst_col", col0, 4'b0000);
      chk("rst_cv", cv0, 1'b0);
      arst_n = 1'b1;
      step();
      spr_x[PW-1:0] = 10'd100;
      spr_y[PW-1:0] = 10'd1;
      spr_en = 4'b0001;
      spr_color[7:0] = 8'h1C;
      spr_bitmap[BM-1:0] = '1;
      do_line(1'b1);
      chk("f1_y0_x100", lb[100], 8'h25);
      chk("f1_cv", cv_f, 1'b1);
      chk("f1_col", col_f, 4'b0000);
      chk("f1_cv_fall", cv_n, 1'b0);
      stall_k = 132;
      do_line(1'b0);
      stall_k = -1;
      chk("y1_x99", lb[99], 8'h25);
      chk("y1_x100", lb[100], 8'h1C);
      chk("y1_x131", lb[131], 8'h1C);
      chk("y1_x132", lb[132], 8'h25);
      chk("blank_black", lb[640], 8'h00);
      chk("hsync_d640", hb[640], 1'b0);
      chk("hsync_d641", hb[641], 1'b1);
      for (int y = 2; y < 16; y++) do_line(1'b0);
      do_line(1'b0);
      chk("y16_x131", lb[131], 8'h1C);
      do_line(1'b0);
      chk("y17_x100", lb[100], 8'h25);
      spr_x[PW-1:0] = 10'd200;
      spr_y[PW-1:0] = 10'd0;
      spr_color[7:0] = 8'hE0;
      spr_x[3*PW-1:2*PW] = 10'd210;
      spr_y[3*PW-1:2*PW] = 10'd0;
      spr_color[23:16] = 8'h03;
      spr_bitmap[3*BM-1:2*BM] = '1;
      spr_en = 4'b0101;
      do_line(1'b1);
      chk("f2_col", col_f, 4'b0000);
      chk("pri_x199", lb[199], 8'h25);
      chk("pri_x205", lb[205], 8'hE0);
      chk("pri_x215", lb[215], 8'hE0);
      chk("pri_x235", lb[235], 8'h03);
      chk("pri_x242", lb[242], 8'h25);
      spr_x[PW-1:0] = 10'd630;
      spr_x[3*PW-1:2*PW] = 10'd700;
      do_line(1'b1);
      chk("f3_col", col_f, 4'b0101);
      chk("f3_cv", cv_f, 1'b1);
      chk("f3_cv_fall", cv_n, 1'b0);
      chk("clip_x0", lb[0], 8'h25);
      chk("clip_x629", lb[629], 8'h25);
      chk("clip_x630", lb[630], 8'hE0);
      chk("clip_x639", lb[639], 8'hE0);
      do_line(1'b0);
      chk("nowrap_x0", lb[0], 8'h25);
      chk("nowrap_x21", lb[21], 8'h25);
      vsync_in = 1'b1;
      for (int k = 0; k < 300; k++) begin
         data_enable = 1'b1;
         step();
      end
      chk("pre_rst_vga", vga0, 8'h25);
      chk("pre_rst_vsync", vs0, 1'b1);
      #2 arst_n = 1'b0;
      #1;
      chk("async_vga", vga0, 8'h00);
      chk("async_vsync", vs0, 1'b0);
      chk("async_col", col0, 4'b0000);
      chk("async_cv", cv0, 1'b0);
      #2 arst_n = 1'b1;
      for (int k = 300; k < HT; k++) begin
         data_enable = k < 640;
         hsync_in = k >= 641;
         step();
         lb[k-1] = vga0;
      end
      chk("post_rst_x400", lb[400], 8'h00);
      vsync_in = 1'b0;
      do_line(1'b0);
      chk("post_rst_line", lb[100], 8'h00);
      spr_x[PW-1:0] = 10'd100;
      spr_color[7:0] = 8'h1C;
      spr_en = 4'b0001;
      do_line(1'b1);
      chk("f4_col", col_f, 4'b0000);
      chk("f4_x100", lb[100], 8'h1C);
      spr_x[PW-1:0] = 10'd300;
      do_line(1'b0);
      chk("dbuf_old_x100", lb[100], 8'h1C);
      chk("dbuf_old_x300", lb[300], 8'h25);
      do_line(1'b1);
      chk("dbuf_new_x100", lb[100], 8'h25);
      chk("dbuf_new_x300", lb[300], 8'h1C);
      chk("dbuf_new_x331", lb[331], 8'h1C);
      spr_x[PW-1:0] = 10'd0;
      spr_bitmap[BM-1:0] = '0;
      spr_bitmap[0] = 1'b1;
      spr_bitmap[BM-1] = 1'b1;
      do_line(1'b1);
      chk("bm_0_0", lb1[0], 8'h1C);
      chk("bm_1_0", lb1[1], 8'h25);
      chk("bm_15_0", lb1[15], 8'h25);
      for (int y = 1; y < 7; y++) do_line(1'b0);
      do_line(1'b0);
      chk("bm_15_7", lb1[15], 8'h1C);
      chk("bm_14_7", lb1[14], 8'h25);
      chk("bm_0_7", lb1[0], 8'h25);
      chk("bm_16_7", lb1[16], 8'h25);
      do_line(1'b0);
      chk("bm_15_8", lb1[15], 8'h25);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor to the single-sprite VGA pixel path: draws NUM_SPRITES bitmap sprites over a background colour, with integer scaling, fixed priority and per-frame collision detection.
- Sits between vga_timings (sync/data_enable/frame inputs) and the VGA pins.
- Runs on the system clock with a pixel strobe (pix_en) instead of a derived clock.
- Sprite state is double-buffered at frame start, so game logic may update positions at any time without tearing.

Parameters:
NUM_SPRITES, 4, number of sprite channels (1..8); index 0 has highest priority
RES_H, 640, visible pixels per line
RES_V, 480, visible lines per frame
SPR_W, 16, sprite bitmap width in source pixels
SPR_H, 8, sprite bitmap height in source pixels
SCALE_LOG2, 1, each source pixel drawn as 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels
POS_W, 10, width of sprite coordinates

Ports:
clk  in  1  system clock
arst_n  in  1  asynchronous reset, active-low
pix_en  in  1  pixel strobe; all pixel-path state advances only when high
hsync_in  in  1  hsync from vga_timings
vsync_in  in  1  vsync from vga_timings
data_enable  in  1  visible-area flag from vga_timings
frame  in  1  start-of-frame pulse, aligned with the pixel (0,0) strobe
spr_x  in  NUM_SPRITES*POS_W  packed sprite x positions (top-left, screen pixels)
spr_y  in  NUM_SPRITES*POS_W  packed sprite y positions
spr_en  in  NUM_SPRITES  sprite visible flags
spr_color  in  NUM_SPRITES*8  RRRGGGBB colour per sprite
spr_bitmap  in  NUM_SPRITES*SPR_W*SPR_H  1 = opaque; row-major, bit 0 = top-left
bg_color  in  8  background colour in the visible area
vga_out  out  8  RRRGGGBB pixel
hsync  out  1  hsync delayed to match vga_out
vsync  out  1  vsync delayed to match vga_out
collision  out  NUM_SPRITES  bit i = sprite i overlapped another opaque sprite last frame
collision_valid  out  1  one-clock pulse when collision is updated

Behaviour:
- Reset (arst_n=0, asynchronous): vga_out=0, hsync=0, vsync=0, collision=0, collision_valid=0. Counters, shadow registers, pipeline and accumulators are cleared. Shadow spr_en=0, so nothing draws until the first frame pulse.
- Nothing changes on cycles with pix_en=0, except collision_valid, which falls.
- Pixel counters (pixel_x, pixel_y):
  - Increment on pix_en && data_enable.
  - pixel_x wraps at RES_H-1; pixel_y then increments and wraps at RES_V-1.
  - On pix_en && frame, both are forced to 0 (resync), taking priority over increment. The frame pixel itself is (0,0).
- Shadow latch: on pix_en && frame, spr_x, spr_y, spr_en and spr_color are copied into shadow registers used for the whole frame. spr_bitmap is sampled live.
- Stage 1, per sprite, combinational from counters plus shadow state:
  - dx = pixel_x - x and dy = pixel_y - y, computed with POS_W+1 bits signed.
  - hit_i = en_i && 0 <= dx < SPR_W<<SCALE_LOG2 && 0 <= dy < SPR_H<<SCALE_LOG2.
  - Bit index = (dy>>SCALE_LOG2)*SPR_W + (dx>>SCALE_LOG2).
  - opaque_i = hit_i && bitmap bit.
  - Result registered on pix_en.
- Clipping: sprites extending past RES_H-1 or RES_V-1 are clipped. No horizontal or vertical wrap. x >= RES_H never draws.
- Stage 2, registered on pix_en:
  - If delayed data_enable=0: vga_out=0.
  - Otherwise the lowest-index opaque sprite's colour, else bg_color.
- Latency: vga_out, hsync and vsync appear exactly 2 pix_en strobes after their inputs. hsync_in, vsync_in and data_enable pass through matching 2-stage delays.
- Collision accumulation:
  - When 2 or more opaque_i bits are set in stage 1 with data_enable, every opaque sprite's accumulator bit is set (sticky).
  - On pix_en && frame: collision <= accumulator, collision_valid pulses for 1 clk, and the accumulator clears.
  - The frame pixel's own overlap counts toward the new frame.
- Frame pulse arriving mid-frame (timing glitch): treated as a normal frame start.
- Reset deasserted mid-frame: output stays black until the first frame pulse.

Decomposition:
- Shared constants package (already holds RES_H, RES_V, PIXEL_FREQ): add SPR_W, SPR_H, SCALE_LOG2, the RRRGGGBB colour width and the packed-bus slicing helpers.
- One natural sub-module: sprite_hit (one instance per channel, generated). Inputs: pixel_x, pixel_y, shadow x/y/en, bitmap slice. Outputs: hit and opaque.
- Priority mux, delay lines and collision logic stay in the top level.

Test Plan:
- Reset: hold arst_n low mid-frame -> all outputs 0 immediately without a clock edge; after release, vga_out=0 until the first frame pulse.
- Single sprite: sprite 0 at (100,50), all-opaque bitmap, SCALE_LOG2=1 -> colour exactly on x 100..131, y 50..65; bg_color elsewhere in the visible area; 0 outside it; colour edge 2 strobes after pixel_x=100.
- Priority and collision: sprites 0 and 2 overlapping at (200,200), colours 0xE0 and 0x03 -> overlap shows 0xE0; at the next frame pulse, collision=0b0101 and collision_valid high 1 clk.
- Clipping: sprite at x=630 -> pixels 630..639 drawn, nothing at x 0..21 of the next line; x=700 -> never drawn.
- Double buffering: change spr_x from 100 to 300 mid-frame -> the current frame still draws at 100; the next frame draws at 300.
- Bitmap indexing: only bit 0 and bit SPR_W*SPR_H-1 set, SCALE_LOG2=0, sprite at (0,0) -> colour only at (0,0) and (15,7).
